// File: rtl/mem_display_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_display_pkg
// Purpose  : Shared constants for the memory-byte 7-segment display:
//            digit/page counts, blank pattern and the hex segment table.
// Revision : 1.0 - initial release
// ============================================================================
package mem_display_pkg;

  localparam int NDIG  = 4;
  localparam int NPAGE = 4;

  // All segments off (common-anode, active-low)
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} patterns; entry 15 is written first
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

endpackage
`default_nettype wire

// File: rtl/mem_display_hex7seg.sv
`default_nettype none
// ============================================================================
// Module   : hex7seg
// Purpose  : Combinational nibble to active-low 7-segment decoder.
// Revision : 1.0 - initial release
// ============================================================================
module hex7seg
  import mem_display_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  // Table lookup of the segment pattern
  always_comb begin
    o_seg = HEX_SEG[i_nibble];
  end

endmodule
`default_nettype wire

// File: rtl/mem_display.sv
`default_nettype none
// ============================================================================
// Module   : mem_display
// Purpose  : Scans eight CPU output bytes onto a 4-digit common-anode
//            7-segment display, two bytes per page, auto-cycling 4 pages.
//            Bytes are snapshotted once per frame so a frame never tears.
// Options  : MEM_DISPLAY_HOLD_EN - adds a 'hold' input that freezes the
//            frame counter and page while scanning continues.
// Revision : 1.0 - initial release
// ============================================================================
module mem_display
  import mem_display_pkg::*;
#(
  parameter int SCAN_DIV    = 50000,
  parameter int PAGE_FRAMES = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] mem0,
  input  logic [7:0] mem1,
  input  logic [7:0] mem2,
  input  logic [7:0] mem3,
  input  logic [7:0] mem4,
  input  logic [7:0] mem5,
  input  logic [7:0] mem6,
  input  logic [7:0] mem7,
`ifdef MEM_DISPLAY_HOLD_EN
  input  logic       hold,
`endif
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic [1:0] page
);

  localparam int PRE_W = $clog2(SCAN_DIV);
  localparam int FRM_W = (PAGE_FRAMES > 1) ? $clog2(PAGE_FRAMES) : 1;

  logic [PRE_W-1:0] pre_q,   pre_d;
  logic [1:0]       dig_q,   dig_d;
  logic [FRM_W-1:0] frame_q, frame_d;
  logic [1:0]       page_q,  page_d;
  logic [15:0]      snap_q,  snap_d;
  logic [3:0]       an_q,    an_d;
  logic [6:0]       seg_q,   seg_d;
  logic             dp_q,    dp_d;

  logic             w_tick;
  logic             w_frame_end;
  logic             w_run;
  logic [3:0]       w_nibble;
  logic [6:0]       w_seg;

  // Page advance gate: frozen while hold is asserted
`ifdef MEM_DISPLAY_HOLD_EN
  always_comb w_run = ~hold;
`else
  always_comb w_run = 1'b1;
`endif

  // Scan timing, frame/page counters and per-frame snapshot of the bytes
  always_comb begin
    w_tick      = (pre_q == PRE_W'(SCAN_DIV - 1));
    w_frame_end = w_tick && (dig_q == 2'd3);
    pre_d       = w_tick ? '0 : pre_q + 1'b1;
    dig_d       = w_tick ? dig_q + 1'b1 : dig_q;
    frame_d     = frame_q;
    page_d      = page_q;
    snap_d      = snap_q;
    if (w_frame_end && w_run) begin
      if (frame_q == FRM_W'(PAGE_FRAMES - 1)) begin
        frame_d = '0;
        page_d  = page_q + 1'b1;
      end else begin
        frame_d = frame_q + 1'b1;
      end
    end
    // Snapshot uses the page valid after this edge so a page change and
    // its first frame of data land together
    if (w_frame_end) begin
      case (page_d)
        2'd0:    snap_d = {mem0, mem1};
        2'd1:    snap_d = {mem2, mem3};
        2'd2:    snap_d = {mem4, mem5};
        default: snap_d = {mem6, mem7};
      endcase
    end
  end

  // Select the nibble of the digit currently being scanned
  always_comb begin
    case (dig_q)
      2'd0:    w_nibble = snap_q[3:0];
      2'd1:    w_nibble = snap_q[7:4];
      2'd2:    w_nibble = snap_q[11:8];
      default: w_nibble = snap_q[15:12];
    endcase
  end

  hex7seg u_hex7seg (
    .i_nibble (w_nibble),
    .o_seg    (w_seg)
  );

  // Next output value; the cycle after a tick is blanked to avoid ghosting
  always_comb begin
    an_d  = 4'b1111;
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    if (!w_tick) begin
      an_d  = ~(4'b0001 << dig_q);
      seg_d = w_seg;
      dp_d  = (dig_q != page_q);
    end
  end

  // State and output registers, asynchronously cleared to a dark display
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_q   <= '0;
      dig_q   <= '0;
      frame_q <= '0;
      page_q  <= '0;
      snap_q  <= '0;
      an_q    <= 4'b1111;
      seg_q   <= SEG_BLANK;
      dp_q    <= 1'b1;
    end else begin
      pre_q   <= pre_d;
      dig_q   <= dig_d;
      frame_q <= frame_d;
      page_q  <= page_d;
      snap_q  <= snap_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign an   = an_q;
  assign seg  = seg_q;
  assign dp   = dp_q;
  assign page = page_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_display
// Purpose  : Directed, table-driven bench for mem_display
//            (SCAN_DIV=4, PAGE_FRAMES=2: 16-cycle frames, 32-cycle pages).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_display;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] mem0, mem1, mem2, mem3, mem4, mem5, mem6, mem7;
  logic       hold = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic [1:0] page;

  int errors = 0;
  int checks = 0;
  int n      = 0;   // rising edges since the last reset release

  mem_display #(.SCAN_DIV(4), .PAGE_FRAMES(2)) dut (
    .clk  (clk),
    .rst  (rst),
    .mem0 (mem0), .mem1 (mem1), .mem2 (mem2), .mem3 (mem3),
    .mem4 (mem4), .mem5 (mem5), .mem6 (mem6), .mem7 (mem7),
`ifdef MEM_DISPLAY_HOLD_EN
    .hold (hold),
`endif
    .an   (an),
    .seg  (seg),
    .dp   (dp),
    .page (page)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         n;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic [1:0] page;
  } vec_t;

  localparam int NVEC = 19;
  vec_t tbl [NVEC];

  task automatic step();
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic step_to(input int target);
    while (n < target) step();
  endtask

  task automatic check_all(input string name, input logic [3:0] e_an,
                           input logic [6:0] e_seg, input logic e_dp,
                           input logic [1:0] e_page);
    checks++;
    if (an !== e_an || seg !== e_seg || dp !== e_dp || page !== e_page) begin
      errors++;
      $display("FAIL %s n=%0d: got an=%b seg=%h dp=%b page=%0d, want an=%b seg=%h dp=%b page=%0d",
               name, n, an, seg, dp, page, e_an, e_seg, e_dp, e_page);
    end
  endtask

  task automatic check_page(input string name, input logic [1:0] e_page);
    checks++;
    if (page !== e_page) begin
      errors++;
      $display("FAIL %s n=%0d: got page=%0d, want page=%0d", name, n, page, e_page);
    end
  endtask

  // Watchdog so the run can never hang
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // n, an, seg, dp, page  (output after edge n reflects state after edge n-1)
    tbl[0]  = '{1,   4'b1110, 7'h40, 1'b0, 2'd0};  // frame 0 shows 0000
    tbl[1]  = '{4,   4'b1111, 7'h7F, 1'b1, 2'd0};  // blank after tick
    tbl[2]  = '{5,   4'b1101, 7'h40, 1'b1, 2'd0};
    tbl[3]  = '{17,  4'b1110, 7'h19, 1'b0, 2'd0};  // 4 on dig0, dp lit
    tbl[4]  = '{20,  4'b1111, 7'h7F, 1'b1, 2'd0};
    tbl[5]  = '{21,  4'b1101, 7'h30, 1'b1, 2'd0};  // 3
    tbl[6]  = '{25,  4'b1011, 7'h24, 1'b1, 2'd0};  // 2
    tbl[7]  = '{29,  4'b0111, 7'h79, 1'b1, 2'd0};  // 1
    tbl[8]  = '{31,  4'b0111, 7'h79, 1'b1, 2'd0};  // last lit cycle of page 0
    tbl[9]  = '{32,  4'b1111, 7'h7F, 1'b1, 2'd1};  // page advances with blank
    tbl[10] = '{33,  4'b1110, 7'h21, 1'b1, 2'd1};  // d
    tbl[11] = '{37,  4'b1101, 7'h46, 1'b0, 2'd1};  // C, dp on dig1
    tbl[12] = '{41,  4'b1011, 7'h03, 1'b1, 2'd1};  // b
    tbl[13] = '{45,  4'b0111, 7'h08, 1'b1, 2'd1};  // A
    tbl[14] = '{65,  4'b1110, 7'h00, 1'b1, 2'd2};  // mem5 lo = 8
    tbl[15] = '{73,  4'b1011, 7'h02, 1'b0, 2'd2};  // mem4 lo = 6, dp on dig2
    tbl[16] = '{97,  4'b1110, 7'h40, 1'b1, 2'd3};  // mem7 lo = 0
    tbl[17] = '{109, 4'b0111, 7'h10, 1'b0, 2'd3};  // mem6 hi = 9, dp on dig3
    tbl[18] = '{129, 4'b1110, 7'h19, 1'b0, 2'd0};  // page wrapped to 0

    mem0 = 8'h12; mem1 = 8'h34; mem2 = 8'hAB; mem3 = 8'hCD;
    mem4 = 8'h56; mem5 = 8'h78; mem6 = 8'h9E; mem7 = 8'hF0;

    // Reset held for three cycles
    repeat (3) @(posedge clk);
    #1;
    check_all("reset_hold", 4'b1111, 7'h7F, 1'b1, 2'd0);
    rst = 1'b1;
    n   = 0;

    // Scan, frame snapshot and page cycling
    for (int i = 0; i < NVEC; i++) begin
      step_to(tbl[i].n);
      check_all($sformatf("vec%0d", i), tbl[i].an, tbl[i].seg, tbl[i].dp, tbl[i].page);
    end

    // Mid-frame write to mem0 (during dig1 of frame 8) is deferred a frame
    step_to(133);
    mem0 = 8'hFF;
    step_to(137);
    check_all("midframe_old_dig2", 4'b1011, 7'h24, 1'b1, 2'd0);
    step_to(141);
    check_all("midframe_old_dig3", 4'b0111, 7'h79, 1'b1, 2'd0);
    step_to(153);
    check_all("nextframe_new_dig2", 4'b1011, 7'h0E, 1'b1, 2'd0);
    step_to(157);
    check_all("nextframe_new_dig3", 4'b0111, 7'h0E, 1'b1, 2'd0);

    // Asynchronous reset at dig=2, prescaler=1 while a digit is lit
    step_to(169);
    rst = 1'b0;
    #1;
    check_all("async_reset", 4'b1111, 7'h7F, 1'b1, 2'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    n   = 0;
    step_to(1);
    check_all("restart_dig0", 4'b1110, 7'h40, 1'b0, 2'd0);
    step_to(5);
    check_all("restart_dig1", 4'b1101, 7'h40, 1'b1, 2'd0);
    step_to(33);
    check_all("restart_page1", 4'b1110, 7'h21, 1'b1, 2'd1);

`ifdef MEM_DISPLAY_HOLD_EN
    // Hold on page 1 for ten frames; snapshot keeps refreshing
    hold = 1'b1;
    step_to(97);
    check_all("hold_page_frozen", 4'b1110, 7'h21, 1'b1, 2'd1);
    step_to(100);
    mem3 = 8'h77;
    step_to(113);
    check_all("hold_live_refresh", 4'b1110, 7'h78, 1'b1, 2'd1);
    step_to(193);
    check_page("hold_10_frames", 2'd1);
    hold = 1'b0;
    step_to(223);
    check_page("release_not_yet", 2'd1);
    step_to(224);
    check_page("release_advance", 2'd2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
